spi_master_controller: RTL and testbench
========================================

// Module: spi_master_controller
// PURPOSE
//  Host-side SPI initiator for the clock-master register bus. Serialises a local
//  register request into the 2-byte slave frame (byte0 = {W/R, addr}, byte1 = data
//  or dummy), drives SCLK/MOSI/CS_N in mode 0, and captures the slave's responses.
//  Used by the on-board test harness / supervisory FPGA to read and write
//  clock-master registers. The slave returns ACK on every byte except the read byte.
// PARAMETERS
//  DATA_WIDTH  8       frame byte width; MSB of byte0 is the W/R flag
//  ADDR_WIDTH  7       register address width; must be <= DATA_WIDTH-1
//  CLK_DIV     4       i_clk cycles per SCLK half-period; must be >= 2
//  GAP_CYCLES  8       CS_N-low idle gap between byte0 and byte1; must be >= 1
//  ACK_VALUE   `ACK    expected slave acknowledge byte (address_map.vh)
// PORTS
//  i_clk        in   1           system clock
//  i_rst        in   1           synchronous, active-high reset
//  i_start      in   1           request strobe; sampled only while o_busy=0
//  i_wr         in   1           1 = write, 0 = read; latched with i_start
//  i_addr       in   ADDR_WIDTH  register address; latched with i_start
//  i_wdata      in   DATA_WIDTH  write data; latched with i_start
//  o_busy       out  1           high from the accept edge until o_done
//  o_done       out  1           1-cycle pulse at end of transaction
//  o_rdata      out  DATA_WIDTH  read result; updated only on read completion
//  o_ack_err    out  1           ACK-mismatch status of the last transaction
//  o_spi_sclk   out  1           SPI clock, idle low
//  o_spi_mosi   out  1           SPI data out, MSB first
//  o_spi_cs_n   out  1           chip select, active low
//  i_spi_miso   in   1           SPI data in
// BEHAVIOUR
//  Reset: o_busy=0, o_done=0, o_rdata=0, o_ack_err=0, o_spi_sclk=0, o_spi_mosi=0,
//   o_spi_cs_n=1, FSM=IDLE. A reset mid-frame aborts on the next edge: no o_done.
//  byte0 = {i_wr, zero-pad, i_addr}; byte1 = i_wdata (write) or 8'h00 (read).
//  FSM: IDLE -(i_start)-> SETUP -> SHIFT0 -> GAP -> SHIFT1 -> HOLD -> DONE -> IDLE.
//   IDLE  : i_start=1 latches the inputs, sets o_busy, drives o_spi_cs_n=0.
//   SETUP : CLK_DIV cycles with CS_N low and SCLK low; MOSI = byte bit MSB.
//   SHIFTn: 8 bits, each 2*CLK_DIV cycles: SCLK low CLK_DIV, high CLK_DIV.
//           MISO is sampled on the cycle SCLK rises. MOSI advances on SCLK fall.
//           SCLK ends low.
//   GAP   : GAP_CYCLES cycles, CS_N low, SCLK low. The slave loads its tx byte here.
//   HOLD  : CLK_DIV cycles CS_N low, SCLK low; then CS_N rises entering DONE.
//   DONE  : o_done=1 for 1 cycle, o_busy falls the same edge, status outputs valid.
//  Latency: accept edge to o_done high = 34*CLK_DIV + GAP_CYCLES + 1 cycles
//   (145 at defaults).
//  Status at DONE: resp0 = MISO byte during SHIFT0; resp1 = during SHIFT1.
//   read : o_rdata <= resp1; o_ack_err <= (resp0 != ACK_VALUE).
//   write: o_rdata unchanged; o_ack_err <= (resp0 != ACK_VALUE) | (resp1 != ACK_VALUE).
//  Simultaneous events:
//   - i_start while o_busy=1 (incl. the DONE cycle) is ignored; no queuing.
//   - i_start in the cycle after DONE is accepted.
//   - Latched inputs are immune to later input changes.
//  Counters: the half-period counter counts 0..CLK_DIV-1 and the bit counter 7..0.
//   Neither counter wraps outside its state.
// TESTING
//  1 write addr=7'h15 data=8'h5A, slave returns ACK/ACK -> MOSI 8'h95 then 8'h5A;
//    o_ack_err=0; o_done 145 cycles after start.
//  2 read addr=7'h03, slave returns ACK then 8'hC3 -> MOSI 8'h03,8'h00;
//    o_rdata=8'hC3, o_ack_err=0.
//  3 write, slave returns ACK then 8'h00 -> o_ack_err=1; o_rdata keeps prior 8'hC3.
//  4 i_start pulsed at cycles 10 and 50 of a transaction, and on the DONE cycle
//    -> ignored, exactly one frame on the wire.
//  5 i_rst asserted mid-SHIFT1 -> next edge: CS_N=1, SCLK=0, o_busy=0, no o_done;
//    a following read completes normally.
//  6 Back-to-back: i_start held high continuously -> successive frames each separated
//    by exactly one idle (IDLE) cycle with CS_N high.

Source files
------------

// File: rtl/spi_master_controller.sv
// SPI mode-0 initiator for the clock-master register bus.
// Each request becomes one CS_N-framed, two-byte exchange:
//   byte0 = {W/R, zero pad, address}
//   byte1 = write data, or a zero dummy byte for reads
// The two slave response bytes are kept. At the end of the frame they set the
// read result and the acknowledge-error status.
module spi_master_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  // Acknowledge byte the slave returns on every non-read byte. This default is
  // the register map's ACK code; override it to match the map in use.
  parameter logic [DATA_WIDTH-1:0] ACK_VALUE = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ack_err,
  output logic                  o_spi_sclk,
  output logic                  o_spi_mosi,
  output logic                  o_spi_cs_n,
  input  logic                  i_spi_miso
);

  // Widths of the frame and of the three sequencing counters.
  localparam int FW = 2 * DATA_WIDTH;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  // Frame sequencer states.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_SHIFT0 = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_SHIFT1 = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  logic [2:0]      state;
  logic [2:0]      state_next;
  logic [HW-1:0]   half_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [FW-1:0]   tx_sr;
  logic [FW-1:0]   rx_sr;
  logic [FW-1:0]   frame_word;
  logic            wr_q;

  logic            accept;
  logic            in_shift;
  logic            half_last;
  logic            sclk_rise;
  logic            sclk_fall;
  logic            byte_end;
  logic            gap_last;
  logic [DATA_WIDTH-1:0] resp0;
  logic [DATA_WIDTH-1:0] resp1;

  // Event decode shared by the sequencer, the counters and the pins.
  assign accept    = (state == ST_IDLE) && i_start;
  assign in_shift  = (state == ST_SHIFT0) || (state == ST_SHIFT1);
  assign half_last = (half_cnt == HALF_LAST);
  assign sclk_rise = in_shift && half_last && !o_spi_sclk;
  assign sclk_fall = in_shift && half_last && o_spi_sclk;
  assign byte_end  = sclk_fall && (bit_cnt == '0);
  assign gap_last  = (gap_cnt == GAP_LAST);

  // The two response bytes, in the order the slave sent them.
  assign resp0 = rx_sr[FW-1 -: DATA_WIDTH];
  assign resp1 = rx_sr[DATA_WIDTH-1:0];

  // MOSI is always the MSB of the outgoing frame shifter.
  assign o_spi_mosi = tx_sr[FW-1];

  // Build the outgoing frame from the live request inputs.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path can
    // leave it unassigned (which would infer a latch).
    frame_word = '0;
    frame_word[FW-1] = i_wr;
    frame_word[FW-DATA_WIDTH +: ADDR_WIDTH] = i_addr;
    if (i_wr) begin
      frame_word[DATA_WIDTH-1:0] = i_wdata;
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (i_start)   state_next = ST_SETUP;
      ST_SETUP:  if (half_last) state_next = ST_SHIFT0;
      ST_SHIFT0: if (byte_end)  state_next = ST_GAP;
      ST_GAP:    if (gap_last)  state_next = ST_SHIFT1;
      ST_SHIFT1: if (byte_end)  state_next = ST_HOLD;
      ST_HOLD:   if (half_last) state_next = ST_DONE;
      ST_DONE:                  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // State register. A reset aborts any frame in progress on the next edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Half-period counter. It runs only in the SCLK-paced states and sits at zero
  // everywhere else.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      half_cnt <= '0;
    end else if ((state == ST_SETUP) || in_shift || (state == ST_HOLD)) begin
      half_cnt <= half_last ? '0 : half_cnt + HW'(1);
    end else begin
      half_cnt <= '0;
    end
  end

  // Bit counter. It counts down once per SCLK fall and is preloaded whenever
  // the sequencer is outside a shift state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt <= BIT_LAST;
    end else if (sclk_fall) begin
      bit_cnt <= (bit_cnt == '0) ? BIT_LAST : bit_cnt - BW'(1);
    end else if (!in_shift) begin
      bit_cnt <= BIT_LAST;
    end
  end

  // Inter-byte gap counter. The slave loads its second response byte during
  // this gap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gap_cnt <= '0;
    end else if (state == ST_GAP) begin
      gap_cnt <= gap_cnt + GW'(1);
    end else begin
      gap_cnt <= '0;
    end
  end

  // Outgoing frame shifter. Loading it on accept presents the first MSB while
  // CS_N falls; it then advances on each SCLK fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_sr <= '0;
    end else if (accept) begin
      tx_sr <= frame_word;
    end else if (sclk_fall) begin
      tx_sr <= {tx_sr[FW-2:0], 1'b0};
    end
  end

  // Response shifter and latched direction. MISO is sampled on the cycle SCLK
  // rises.
  always_ff @(posedge i_clk) begin
    // NOTE: these datapath registers are deliberately left out of reset. Accept
    // always loads them before anything reads them, so reset adds nothing.
    if (accept) begin
      rx_sr <= '0;
      wr_q  <= i_wr;
    end else if (sclk_rise) begin
      rx_sr <= {rx_sr[FW-2:0], i_spi_miso};
    end
  end

  // SCLK generation, mode 0: idle low, high for the second half of each bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_spi_sclk <= 1'b0;
    end else if (sclk_rise) begin
      o_spi_sclk <= 1'b1;
    end else if (sclk_fall) begin
      o_spi_sclk <= 1'b0;
    end
  end

  // Chip select. It drops on accept and rises when HOLD completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_spi_cs_n <= 1'b1;
    end else if (accept) begin
      o_spi_cs_n <= 1'b0;
    end else if ((state == ST_HOLD) && half_last) begin
      o_spi_cs_n <= 1'b1;
    end
  end

  // Handshake. o_busy spans accept to completion; o_done pulses as o_busy falls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= (state == ST_DONE);
      if (accept) begin
        o_busy <= 1'b1;
      end else if (state == ST_DONE) begin
        o_busy <= 1'b0;
      end
    end
  end

  // Completion status. Reads also check the address-byte ACK and return byte1.
  // Writes check both ACKs and leave the last read result untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata   <= '0;
      o_ack_err <= 1'b0;
    end else if (state == ST_DONE) begin
      if (wr_q) begin
        o_ack_err <= (resp0 != ACK_VALUE) || (resp1 != ACK_VALUE);
      end else begin
        o_rdata   <= resp1;
        o_ack_err <= (resp0 != ACK_VALUE);
      end
    end
  end

endmodule

// File: tb/tb_spi_master_controller.sv
// Bench for spi_master_controller at its default parameters.
// A cycle-based slave model answers on MISO and records MOSI. A scoreboard
// queue holds the expected frame, read data and ACK status of each request.
module tb_spi_master_controller;

  localparam logic [7:0] ACK = 8'hA5;
  localparam int         LAT = 145;   // 34*CLK_DIV + GAP_CYCLES + 1

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       wr;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       ack_err;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       miso;

  spi_master_controller dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_wr       (wr),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_rdata    (rdata),
    .o_ack_err  (ack_err),
    .o_spi_sclk (sclk),
    .o_spi_mosi (mosi),
    .o_spi_cs_n (cs_n),
    .i_spi_miso (miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    logic        ack_err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_rdata;
  int         n_cmp = 0;
  int         n_err = 0;

  // Slave model state.
  logic [15:0] slv_tx = '0;
  logic [15:0] mosi_cap = '0;
  int          slv_pos = 16;
  int          frames = 0;
  int          done_cnt = 0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;

  // The slave sees CS_N/SCLK edges once per cycle. It shifts MISO on each SCLK
  // fall and captures MOSI on each SCLK rise.
  always @(negedge clk) begin
    if (cs_prev && !cs_n) begin
      frames   = frames + 1;
      slv_pos  = 0;
      mosi_cap = '0;
    end else if (!cs_n && sclk_prev && !sclk) begin
      slv_pos = slv_pos + 1;
    end
    if (!cs_n && !sclk_prev && sclk) begin
      mosi_cap = {mosi_cap[14:0], mosi};
    end
    miso      = (slv_pos < 16) ? slv_tx[15 - slv_pos] : 1'b0;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  // Model a request: build its expected frame and status, then load the slave.
  task automatic push_expected(input logic w, input logic [6:0] a, input logic [7:0] d,
                               input logic [7:0] r0, input logic [7:0] r1);
    exp_t e;
    e.frame = {w, a, (w ? d : 8'h00)};
    if (!w) model_rdata = r1;
    e.rdata   = model_rdata;
    e.ack_err = w ? ((r0 != ACK) || (r1 != ACK)) : (r0 != ACK);
    sb.push_back(e);
    slv_tx = {r0, r1};
  endtask

  // One-cycle start pulse. Returns at the first negedge after the accept edge.
  task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    wr = w; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait, within a cycle budget, for o_done. lat counts edges after accept.
  task automatic wait_done(output int lat, output bit to);
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    to = (done !== 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; wr = 1'b0; addr = '0; wdata = '0; model_rdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, rdata, ack_err, sclk, mosi, cs_n} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b rdata=%h ack_err=%b sclk=%b mosi=%b cs_n=%b, want 0 0 00 0 0 0 1",
               busy, done, rdata, ack_err, sclk, mosi, cs_n);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, cs_n, sclk} !== 3'b010) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b cs_n=%b sclk=%b, want 0 1 0", busy, cs_n, sclk);
    end
  endtask

  task automatic test_write;
    exp_t e; int lat; bit to;
    push_expected(1'b1, 7'h15, 8'h5A, ACK, ACK);
    issue(1'b1, 7'h15, 8'h5A);
    n_cmp++;
    if ({busy, cs_n} !== 2'b10) begin
      n_err++; $display("FAIL write_accept: busy=%b cs_n=%b, want 1 0", busy, cs_n);
    end
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++; if (to || lat != LAT) begin n_err++; $display("FAIL write_latency: got %0d (timeout=%0b), want %0d", lat, to, LAT); end
    n_cmp++; if (mosi_cap !== e.frame) begin n_err++; $display("FAIL write_mosi: got %h, want %h", mosi_cap, e.frame); end
    n_cmp++; if (ack_err !== e.ack_err) begin n_err++; $display("FAIL write_ack_err: got %b, want %b", ack_err, e.ack_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL write_busy_at_done: got %b, want 0", busy); end
  endtask

  task automatic test_read;
    exp_t e; int lat; bit to;
    push_expected(1'b0, 7'h03, 8'hEE, ACK, 8'hC3);
    issue(1'b0, 7'h03, 8'hEE);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++; if (to || lat != LAT) begin n_err++; $display("FAIL read_latency: got %0d (timeout=%0b), want %0d", lat, to, LAT); end
    n_cmp++; if (mosi_cap !== e.frame) begin n_err++; $display("FAIL read_mosi: got %h, want %h", mosi_cap, e.frame); end
    n_cmp++; if (rdata !== e.rdata) begin n_err++; $display("FAIL read_rdata: got %h, want %h", rdata, e.rdata); end
    n_cmp++; if (ack_err !== e.ack_err) begin n_err++; $display("FAIL read_ack_err: got %b, want %b", ack_err, e.ack_err); end
  endtask

  task automatic test_ack_err;
    exp_t e; int lat; bit to;
    // Write with a bad data-byte ACK: error is set and rdata is retained.
    push_expected(1'b1, 7'h40, 8'h81, ACK, 8'h00);
    issue(1'b1, 7'h40, 8'h81);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++; if (to || mosi_cap !== e.frame) begin n_err++; $display("FAIL wr_err_mosi: got %h (timeout=%0b), want %h", mosi_cap, to, e.frame); end
    n_cmp++; if (ack_err !== e.ack_err) begin n_err++; $display("FAIL wr_err_ack_err: got %b, want %b", ack_err, e.ack_err); end
    n_cmp++; if (rdata !== e.rdata) begin n_err++; $display("FAIL wr_err_rdata_kept: got %h, want %h", rdata, e.rdata); end
    // Read with a bad address-byte ACK: error is set and rdata still updates.
    push_expected(1'b0, 7'h7F, 8'h00, 8'h5A, 8'h96);
    issue(1'b0, 7'h7F, 8'h00);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++; if (to || mosi_cap !== e.frame) begin n_err++; $display("FAIL rd_err_mosi: got %h (timeout=%0b), want %h", mosi_cap, to, e.frame); end
    n_cmp++; if (ack_err !== e.ack_err) begin n_err++; $display("FAIL rd_err_ack_err: got %b, want %b", ack_err, e.ack_err); end
    n_cmp++; if (rdata !== e.rdata) begin n_err++; $display("FAIL rd_err_rdata: got %h, want %h", rdata, e.rdata); end
  endtask

  task automatic test_ignored_start;
    exp_t e; int lat; int f0; int d0;
    @(negedge clk);
    f0 = frames; d0 = done_cnt;
    push_expected(1'b1, 7'h7F, 8'hFF, ACK, ACK);
    issue(1'b1, 7'h7F, 8'hFF);
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
      // Strobes at cycles 10 and 50 and on the DONE cycle must all be ignored.
      start = (lat == 10) || (lat == 50) || (lat == LAT - 1);
      if (lat == 20) begin wr = 1'b0; addr = 7'h00; wdata = 8'h00; end
    end
    start = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (done !== 1'b1 || lat != LAT) begin n_err++; $display("FAIL ignore_latency: got %0d, want %0d", lat, LAT); end
    n_cmp++; if (mosi_cap !== e.frame) begin n_err++; $display("FAIL ignore_latched_mosi: got %h, want %h", mosi_cap, e.frame); end
    repeat (200) @(negedge clk);
    n_cmp++;
    if (frames != f0 + 1 || done_cnt != d0 + 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_single_frame: frames=%0d dones=%0d busy=%b, want %0d %0d 0", frames - f0, done_cnt - d0, busy, 1, 1);
    end
  endtask

  task automatic test_reset_mid_frame;
    exp_t e; int lat; bit to; int d0;
    d0 = done_cnt;
    push_expected(1'b0, 7'h11, 8'h00, ACK, 8'h77);
    issue(1'b0, 7'h11, 8'h00);
    repeat (100) @(negedge clk);   // well inside SHIFT1
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cs_n, sclk, busy, done} !== 4'b1000) begin
      n_err++; $display("FAIL abort_pins: cs_n=%b sclk=%b busy=%b done=%b, want 1 0 0 0", cs_n, sclk, busy, done);
    end
    void'(sb.pop_front());
    model_rdata = 8'h00;
    rst = 1'b0;
    repeat (200) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0 || rdata !== 8'h00) begin
      n_err++; $display("FAIL abort_no_done: dones=%0d rdata=%h, want 0 00", done_cnt - d0, rdata);
    end
    push_expected(1'b0, 7'h2A, 8'h00, ACK, 8'h3C);
    issue(1'b0, 7'h2A, 8'h00);
    wait_done(lat, to);
    e = sb.pop_front();
    n_cmp++; if (to || lat != LAT) begin n_err++; $display("FAIL post_abort_latency: got %0d (timeout=%0b), want %0d", lat, to, LAT); end
    n_cmp++; if (mosi_cap !== e.frame) begin n_err++; $display("FAIL post_abort_mosi: got %h, want %h", mosi_cap, e.frame); end
    n_cmp++; if (rdata !== e.rdata || ack_err !== e.ack_err) begin n_err++; $display("FAIL post_abort_status: got %h/%b, want %h/%b", rdata, ack_err, e.rdata, e.ack_err); end
  endtask

  task automatic test_back_to_back;
    exp_t e; int lat; bit to;
    for (int i = 0; i < 3; i++) push_expected(1'b1, 7'h22, 8'h11, ACK, ACK);
    @(negedge clk);
    wr = 1'b1; addr = 7'h22; wdata = 8'h11; start = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      wait_done(lat, to);
      if (f == 2) start = 1'b0;
      e = sb.pop_front();
      n_cmp++; if (to || lat != LAT) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d (timeout=%0b), want %0d", f, lat, to, LAT); end
      n_cmp++; if (mosi_cap !== e.frame || ack_err !== e.ack_err) begin n_err++; $display("FAIL b2b_frame[%0d]: got %h/%b, want %h/%b", f, mosi_cap, ack_err, e.frame, e.ack_err); end
      n_cmp++; if ({cs_n, busy} !== 2'b10) begin n_err++; $display("FAIL b2b_idle[%0d]: cs_n=%b busy=%b, want 1 0", f, cs_n, busy); end
      @(negedge clk);
      n_cmp++;
      if ({cs_n, busy} !== ((f < 2) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL b2b_restart[%0d]: cs_n=%b busy=%b, want %b", f, cs_n, busy, (f < 2) ? 2'b01 : 2'b10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ack_err();
    test_ignored_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
